// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Shares one single-port memory between an instruction-fetch master (m0,
//   read-only) and a load/store master (m1). At most one transaction is in
//   flight: the grant, the memory request and the forwarded fields are all
//   combinational in the IDLE cycle. The response returns combinationally
//   from mem_rvalid/mem_rdata. A wait counter enforces a timeout of TMO cycles
//   after grant.
//
//   Build option: define ARB_ROUND_ROBIN_EN to make simultaneous requests
//   alternate between masters. Without it, m1 always wins a tie.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   m0_req/m0_addr              fetch request and address
//   m0_gnt/m0_rvalid/m0_rdata/m0_err   grant pulse, response, data, timeout flag
//   m1_req/m1_we/m1_addr/m1_wdata/m1_wstrb   load/store request and fields
//   m1_gnt/m1_rvalid/m1_rdata/m1_err   as for m0
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb   shared memory request
//   mem_rvalid/mem_rdata        memory response
//
// States
//   IDLE  | no transaction outstanding; arbitrate and issue
//   WAIT0 | m0 transaction outstanding, waiting for mem_rvalid or timeout
//   WAIT1 | m1 transaction outstanding, waiting for mem_rvalid or timeout

module bus_arbiter #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int TMO = 16
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_req,
    input  logic [AW-1:0]   m0_addr,
    output logic            m0_gnt,
    output logic            m0_rvalid,
    output logic [DW-1:0]   m0_rdata,
    output logic            m0_err,

    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [AW-1:0]   m1_addr,
    input  logic [DW-1:0]   m1_wdata,
    input  logic [DW/8-1:0] m1_wstrb,
    output logic            m1_gnt,
    output logic            m1_rvalid,
    output logic [DW-1:0]   m1_rdata,
    output logic            m1_err,

    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT0 = 2'd1,
        WAIT1 = 2'd2
    } state_t;

    // Counter holds (cycles spent in WAIT) - 1, so the timeout cycle is the
    // one where it equals TMO-1: exactly TMO cycles after the grant.
    localparam logic [7:0] CNT_LAST = 8'(TMO - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       grant0, grant1;
    logic       timeout;

`ifdef ARB_ROUND_ROBIN_EN
    logic       last_m1, last_m1_nxt;
`endif

    // Arbitration, only meaningful in IDLE.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (m0_req && m1_req) begin
                grant0 = last_m1;
                grant1 = !last_m1;
            end else begin
                grant0 = m0_req;
                grant1 = m1_req;
            end
`else
            grant1 = m1_req;
            grant0 = m0_req && !m1_req;
`endif
        end
    end

    assign timeout = (wait_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        last_m1_nxt = last_m1;
        if (grant1) begin
            last_m1_nxt = 1'b1;
        end else if (grant0) begin
            last_m1_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_m1 <= 1'b1;
        end else begin
            last_m1 <= last_m1_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        m0_gnt       = 1'b0;
        m0_rvalid    = 1'b0;
        m0_rdata     = '0;
        m0_err       = 1'b0;
        m1_gnt       = 1'b0;
        m1_rvalid    = 1'b0;
        m1_rdata     = '0;
        m1_err       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_wstrb    = '0;

        case (state)
            IDLE: begin
                if (grant0) begin
                    m0_gnt       = 1'b1;
                    mem_req      = 1'b1;
                    mem_addr     = m0_addr;
                    wait_cnt_nxt = 8'd0;
                    state_nxt    = WAIT0;
                end else if (grant1) begin
                    m1_gnt       = 1'b1;
                    mem_req      = 1'b1;
                    mem_we       = m1_we;
                    mem_addr     = m1_addr;
                    mem_wdata    = m1_wdata;
                    mem_wstrb    = m1_wstrb;
                    wait_cnt_nxt = 8'd0;
                    state_nxt    = WAIT1;
                end
            end
            WAIT0: begin
                // A response in the timeout cycle wins over the error.
                if (mem_rvalid) begin
                    m0_rvalid = 1'b1;
                    m0_rdata  = mem_rdata;
                    state_nxt = IDLE;
                end else if (timeout) begin
                    m0_rvalid = 1'b1;
                    m0_err    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            WAIT1: begin
                if (mem_rvalid) begin
                    m1_rvalid = 1'b1;
                    m1_rdata  = mem_rdata;
                    state_nxt = IDLE;
                end else if (timeout) begin
                    m1_rvalid = 1'b1;
                    m1_err    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs are combinational from inputs, so hold them quiet while
        // reset is asserted rather than waiting for the state to clear.
        if (rst) begin
            m0_gnt    = 1'b0;
            m0_rvalid = 1'b0;
            m0_rdata  = '0;
            m0_err    = 1'b0;
            m1_gnt    = 1'b0;
            m1_rvalid = 1'b0;
            m1_rdata  = '0;
            m1_err    = 1'b0;
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            mem_wstrb = '0;
        end
    end

endmodule
